alu_result_serializer: RTL

- Downstream end of the ALU result interface: captures a registered ALU result (data bus plus one-cycle valid flag) and sends it to the UART transmitter as consecutive bytes, LSB byte first.
- Sits between the ALU output stage and the UART TX parallel-load port, alongside the system controller.
- Owns the byte sequencing and the TX busy/valid handshake, so the controller only has to issue ALU operations.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_result_serializer_if.sv | 35 +++
 rtl/alu_result_serializer.sv | 88 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
//   state_e : serializer FSM state encoding (2 bits)
//   BYTE_W  : width of one UART byte
//   ALU_W   : default ALU result width, shared with the ALU units
package alu_pkg;

    localparam int BYTE_W = 8;
    localparam int ALU_W  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_result_serializer_if.sv
// Bundle of the ALU-result and UART-TX handshake signals around the serializer.
//   ALU_OUT, OUT_Valid : registered ALU result and its one-cycle strobe
//   TX_Busy            : UART TX busy flag
//   TX_P_DATA, TX_D_VLD: byte and one-cycle load strobe to UART TX
//   Ready, Overrun     : accept status and dropped-result pulse
// Handshake: a result is taken when OUT_Valid=1 on a rising edge while
// Ready=1; OUT_Valid with Ready=0 drops the result and pulses Overrun.
// A byte is handed to the TX on the single cycle TX_D_VLD=1, issued only
// after TX_Busy was seen low; the TX acknowledges by raising TX_Busy.
// modport master: the environment (ALU output stage + UART TX).
// modport slave : the serializer itself.
interface alu_result_serializer_if #(
    parameter int Width = alu_pkg::ALU_W
);
    import alu_pkg::*;

    logic [Width-1:0]  ALU_OUT;
    logic              OUT_Valid;
    logic              TX_Busy;
    logic [BYTE_W-1:0] TX_P_DATA;
    logic              TX_D_VLD;
    logic              Ready;
    logic              Overrun;

    modport master (
        output ALU_OUT, OUT_Valid, TX_Busy,
        input  TX_P_DATA, TX_D_VLD, Ready, Overrun
    );

    modport slave (
        input  ALU_OUT, OUT_Valid, TX_Busy,
        output TX_P_DATA, TX_D_VLD, Ready, Overrun
    );

endinterface

// File: rtl/alu_result_serializer.sv
// Captures one ALU result and sends it to the UART TX as NUM_BYTES bytes,
// least significant byte first, pacing each byte on the TX busy flag.
// Ports:
//   CLK       : system clock, rising edge
//   RST       : synchronous active-high reset
//   bus       : alu_result_serializer_if.slave (ALU result in, TX byte out)
//   dbg_state : current FSM state, for observation only
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int Width = ALU_W  // multiple of 8, at least 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    alu_result_serializer_if.slave   bus,
    output state_e                   dbg_state
);

    localparam int NUM_BYTES = Width / BYTE_W;
    // Keep the counter at least one bit wide so Width=8 still elaborates.
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    state_e            state_q;
    logic [Width-1:0]  shift_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [BYTE_W-1:0] tx_p_data_q;
    logic              tx_d_vld_q;
    logic              overrun_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            tx_p_data_q <= '0;
            tx_d_vld_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tx_d_vld_q <= 1'b0;
            // Any result offered outside IDLE is dropped; the transfer in
            // flight carries on untouched.
            overrun_q  <= bus.OUT_Valid && (state_q != IDLE);

            case (state_q)
                IDLE: begin
                    if (bus.OUT_Valid) begin
                        shift_q    <= bus.ALU_OUT;
                        byte_cnt_q <= '0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    // TX may still be finishing a frame from another source.
                    if (!bus.TX_Busy) begin
                        tx_p_data_q <= shift_q[BYTE_W-1:0];
                        tx_d_vld_q  <= 1'b1;
                        state_q     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.TX_Busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TX_Busy) begin
                        if (byte_cnt_q == LAST_CNT) begin
                            state_q <= IDLE;
                        end else begin
                            shift_q    <= shift_q >> BYTE_W;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.TX_P_DATA = tx_p_data_q;
    assign bus.TX_D_VLD  = tx_d_vld_q;
    assign bus.Overrun   = overrun_q;
    assign bus.Ready     = (state_q == IDLE);
    assign dbg_state     = state_q;

endmodule
